// File: rtl/alu_multiciclo.sv
// ---------------------------------------------------------------------------
// alu_multiciclo
// Sequential execution unit driven by the 3-bit ALU operation code.
// Logic/arithmetic ops (and, or, add, sub, slt) finish one cycle after the
// accepting edge. mul and div run 32 iterations of shift-add / restoring
// division on operand magnitudes, followed by a sign correction.
//
// Ports:
//   clock          system clock, rising-edge active
//   reset          asynchronous, active-low; clears all state
//   inicio         start request, honoured only while not busy
//   sinalOperacao  op code: 000 and, 001 or, 010 add, 011 mul, 100 div,
//                  101 reserved, 110 sub, 111 slt
//   a, b           32-bit operands, sampled on the accepting edge only
//   resultado      low word / quotient / simple-op result
//   resto          product high word / remainder / 0
//   zero           resultado == 0, registered alongside resultado
//   divZero        last completed op was a div with b == 0
//   opInvalida     last completed op used the reserved code 101
//   ocupado        high while a mul/div is iterating
//   pronto         one-cycle pulse when the results are valid
// ---------------------------------------------------------------------------
module alu_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [2:0]  sinalOperacao,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] resultado,
  output logic [31:0] resto,
  output logic        zero,
  output logic        divZero,
  output logic        opInvalida,
  output logic        ocupado,
  output logic        pronto
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_RES = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [4:0]  contador_q, contador_d;
  // Shared 64-bit working register: {partial product high, multiplier} for
  // mul, {partial remainder, dividend/quotient} for div.
  logic [63:0] acc_q, acc_d;
  // Multiplicand magnitude for mul, divisor magnitude for div.
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_orig_q, a_orig_d;
  logic [2:0]  op_q, op_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_a_q, neg_a_d;
  logic [31:0] resultado_q, resultado_d;
  logic [31:0] resto_q, resto_d;
  logic        zero_q, zero_d;
  logic        div_zero_q, div_zero_d;
  logic        op_invalida_q, op_invalida_d;

  logic [31:0] abs_a, abs_b;
  logic [31:0] simples;
  logic [32:0] mul_soma;
  logic [63:0] mul_prox;
  logic [32:0] div_teste;
  logic [63:0] div_prox;
  logic [63:0] produto;

  // Datapath for one iteration step plus the single-cycle results.
  // The mul step adds the multiplicand into the high half when the current
  // multiplier bit is set, then shifts the 65-bit {carry, acc} right.
  // The div step shifts the next dividend bit into the remainder and keeps
  // the subtraction only when it does not borrow; the quotient bit enters
  // at the bottom as the dividend bits leave at the top.
  always_comb begin
    abs_a     = a[31] ? (32'd0 - a) : a;
    abs_b     = b[31] ? (32'd0 - b) : b;
    mul_soma  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_prox  = {mul_soma, acc_q[31:1]};
    div_teste = acc_q[63:31] - {1'b0, opnd_q};
    if (div_teste[32]) begin
      div_prox = {acc_q[62:0], 1'b0};
    end else begin
      div_prox = {div_teste[31:0], acc_q[30:0], 1'b1};
    end
    produto = neg_res_q ? (64'd0 - mul_prox) : mul_prox;
    simples = 32'd0;
    case (sinalOperacao)
      OP_AND:  simples = a & b;
      OP_OR:   simples = a | b;
      OP_ADD:  simples = a + b;
      OP_SUB:  simples = a - b;
      OP_SLT:  simples = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: simples = 32'd0;
    endcase
  end

  // Next-state and output-register logic. CONCLUI accepts a new start just
  // like OCIOSO so that back-to-back operations need no bubble.
  always_comb begin
    estado_d      = estado_q;
    contador_d    = contador_q;
    acc_d         = acc_q;
    opnd_d        = opnd_q;
    a_orig_d      = a_orig_q;
    op_d          = op_q;
    neg_res_d     = neg_res_q;
    neg_a_d       = neg_a_q;
    resultado_d   = resultado_q;
    resto_d       = resto_q;
    div_zero_d    = div_zero_q;
    op_invalida_d = op_invalida_q;

    case (estado_q)
      OCIOSO, CONCLUI: begin
        estado_d = OCIOSO;
        if (inicio) begin
          op_d       = sinalOperacao;
          a_orig_d   = a;
          neg_res_d  = a[31] ^ b[31];
          neg_a_d    = a[31];
          contador_d = 5'd0;
          if (sinalOperacao == OP_MUL) begin
            acc_d    = {32'd0, abs_b};
            opnd_d   = abs_a;
            estado_d = CALCULA;
          end else if (sinalOperacao == OP_DIV) begin
            acc_d    = {32'd0, abs_a};
            opnd_d   = abs_b;
            estado_d = CALCULA;
          end else begin
            resultado_d   = simples;
            resto_d       = 32'd0;
            div_zero_d    = 1'b0;
            op_invalida_d = (sinalOperacao == OP_RES);
            estado_d      = CONCLUI;
          end
        end
      end

      CALCULA: begin
        contador_d = contador_q + 5'd1;
        acc_d      = (op_q == OP_DIV) ? div_prox : mul_prox;
        if (contador_q == 5'd31) begin
          estado_d      = CONCLUI;
          op_invalida_d = 1'b0;
          div_zero_d    = 1'b0;
          if (op_q == OP_DIV) begin
            if (opnd_q == 32'd0) begin
              resultado_d = 32'hFFFF_FFFF;
              resto_d     = a_orig_q;
              div_zero_d  = 1'b1;
            end else begin
              resultado_d = neg_res_q ? (32'd0 - div_prox[31:0]) : div_prox[31:0];
              resto_d     = neg_a_q ? (32'd0 - div_prox[63:32]) : div_prox[63:32];
            end
          end else begin
            resultado_d = produto[31:0];
            resto_d     = produto[63:32];
          end
        end
      end

      default: estado_d = OCIOSO;
    endcase

    zero_d = (resultado_d == 32'd0);
  end

  // State register; reset drops everything to the idle, cleared condition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q      <= OCIOSO;
      contador_q    <= 5'd0;
      acc_q         <= 64'd0;
      opnd_q        <= 32'd0;
      a_orig_q      <= 32'd0;
      op_q          <= 3'd0;
      neg_res_q     <= 1'b0;
      neg_a_q       <= 1'b0;
      resultado_q   <= 32'd0;
      resto_q       <= 32'd0;
      zero_q        <= 1'b1;
      div_zero_q    <= 1'b0;
      op_invalida_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      contador_q    <= contador_d;
      acc_q         <= acc_d;
      opnd_q        <= opnd_d;
      a_orig_q      <= a_orig_d;
      op_q          <= op_d;
      neg_res_q     <= neg_res_d;
      neg_a_q       <= neg_a_d;
      resultado_q   <= resultado_d;
      resto_q       <= resto_d;
      zero_q        <= zero_d;
      div_zero_q    <= div_zero_d;
      op_invalida_q <= op_invalida_d;
    end
  end

  assign resultado  = resultado_q;
  assign resto      = resto_q;
  assign zero       = zero_q;
  assign divZero    = div_zero_q;
  assign opInvalida = op_invalida_q;
  assign ocupado    = (estado_q == CALCULA);
  assign pronto     = (estado_q == CONCLUI);

endmodule

// File: tb/tb_alu_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_alu_multiciclo
// Self-checking bench for alu_multiciclo: directed cases followed by random
// operations, all compared against a signed-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inicio = 1'b0;
  logic [2:0]  sinalOperacao = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] resultado;
  logic [31:0] resto;
  logic        zero;
  logic        divZero;
  logic        opInvalida;
  logic        ocupado;
  logic        pronto;

  int          checks = 0;
  int          fails  = 0;

  logic [31:0] expRes;
  logic [31:0] expResto;
  logic        expDz;
  logic        expInv;
  logic [2:0]  curOp;

  alu_multiciclo dut (
    .clock         (clock),
    .reset         (reset),
    .inicio        (inicio),
    .sinalOperacao (sinalOperacao),
    .a             (a),
    .b             (b),
    .resultado     (resultado),
    .resto         (resto),
    .zero          (zero),
    .divZero       (divZero),
    .opInvalida    (opInvalida),
    .ocupado       (ocupado),
    .pronto        (pronto)
  );

  always #5 clock = ~clock;

  // Reference model: plain signed arithmetic on wide integers.
  function automatic void model(input logic [2:0] op, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] r,
                                output logic [31:0] h, output logic dz,
                                output logic inv);
    longint p;
    longint q;
    longint rm;
    r = 32'd0; h = 32'd0; dz = 1'b0; inv = 1'b0;
    case (op)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: r = x + y;
      3'b110: r = x - y;
      3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011: begin
        p = longint'($signed(x)) * longint'($signed(y));
        r = p[31:0];
        h = p[63:32];
      end
      3'b100: begin
        if (y == 32'd0) begin
          r = 32'hFFFF_FFFF; h = x; dz = 1'b1;
        end else begin
          q  = longint'($signed(x)) / longint'($signed(y));
          rm = longint'($signed(x)) % longint'($signed(y));
          r  = q[31:0];
          h  = rm[31:0];
        end
      end
      default: inv = 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drives an operation at the current time and returns just after the
  // accepting edge with the inputs scrambled and inicio dropped.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x,
                               input logic [31:0] y);
    sinalOperacao = op;
    a             = x;
    b             = y;
    inicio        = 1'b1;
    model(op, x, y, expRes, expResto, expDz, expInv);
    curOp = op;
    @(posedge clock);
    #1;
    inicio        = 1'b0;
    a             = $urandom;
    b             = $urandom;
    sinalOperacao = 3'($urandom_range(0, 7));
  endtask

  // Waits (bounded) for pronto and checks latency, busy time and results.
  // A non-zero pulseAt raises inicio with an add for one cycle mid-operation.
  task automatic waitDone(input int pulseAt);
    int  cycles;
    int  busy;
    bit  done;
    bit  multi;
    cycles = 0; busy = 0; done = 0;
    multi  = (curOp == 3'b011) || (curOp == 3'b100);
    while (!done && cycles < 40) begin
      @(negedge clock);
      cycles++;
      if (ocupado) busy++;
      if (pronto) done = 1;
      if (pulseAt != 0 && cycles == pulseAt) begin
        inicio = 1'b1; sinalOperacao = 3'b010; a = 32'd1; b = 32'd1;
      end else if (pulseAt != 0 && cycles == pulseAt + 1) begin
        inicio = 1'b0;
      end
    end
    checkOutput("latency", 64'(cycles), multi ? 64'd33 : 64'd1);
    checkOutput("busy cycles", 64'(busy), multi ? 64'd32 : 64'd0);
    checkOutput("resultado", 64'(resultado), 64'(expRes));
    checkOutput("resto", 64'(resto), 64'(expResto));
    checkOutput("zero", 64'(zero), 64'(expRes == 32'd0));
    checkOutput("divZero", 64'(divZero), 64'(expDz));
    checkOutput("opInvalida", 64'(opInvalida), 64'(expInv));
  endtask

  // One idle cycle after completion: pronto must drop and results must hold.
  task automatic checkHold();
    inicio = 1'b0;
    @(negedge clock);
    checkOutput("pronto pulse width", 64'(pronto), 64'd0);
    checkOutput("resultado hold", 64'(resultado), 64'(expRes));
    checkOutput("resto hold", 64'(resto), 64'(expResto));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " resultado"}, 64'(resultado), 64'd0);
    checkOutput({tag, " resto"}, 64'(resto), 64'd0);
    checkOutput({tag, " zero"}, 64'(zero), 64'd1);
    checkOutput({tag, " divZero"}, 64'(divZero), 64'd0);
    checkOutput({tag, " opInvalida"}, 64'(opInvalida), 64'd0);
    checkOutput({tag, " ocupado"}, 64'(ocupado), 64'd0);
    checkOutput({tag, " pronto"}, 64'(pronto), 64'd0);
  endtask

  initial begin
    int prontoSeen;
    logic [2:0]  rop;
    logic [31:0] rx, ry;

    // Power-on reset
    #2 reset = 1'b0;
    #1 checkResetValues("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Simple ops, back-to-back
    applyStimulus(3'b010, 32'h7FFF_FFFF, 32'd1);
    waitDone(0);
    checkHold();
    applyStimulus(3'b111, 32'hFFFF_FFFF, 32'd1);
    waitDone(0);
    applyStimulus(3'b110, 32'd5, 32'd5);
    waitDone(0);

    // Multi-cycle ops
    applyStimulus(3'b011, 32'hFFFF_FFFD, 32'd7);
    waitDone(0);
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2);
    waitDone(0);
    checkHold();

    // Start request during CALCULA must be ignored
    applyStimulus(3'b100, 32'd100, 32'hFFFF_FFF9);
    waitDone(10);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(0);
    applyStimulus(3'b100, 32'd9, 32'd0);
    waitDone(0);
    checkHold();

    // Reset in the middle of a division
    applyStimulus(3'b100, 32'd1234, 32'd5);
    repeat (15) @(negedge clock);
    reset = 1'b0;
    #1 checkResetValues("mid reset");
    prontoSeen = 0;
    repeat (3) begin
      @(negedge clock);
      if (pronto) prontoSeen++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (pronto) prontoSeen++;
    end
    checkOutput("no pronto after reset", 64'(prontoSeen), 64'd0);

    // Reserved code, then a valid op clears the flag
    applyStimulus(3'b101, 32'd77, 32'd88);
    waitDone(0);
    applyStimulus(3'b010, 32'd10, 32'd20);
    waitDone(0);

    // Random operations against the model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rx  = $urandom;
      ry  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if ($urandom_range(0, 4) == 0) rx = 32'h8000_0000;
      applyStimulus(rop, rx, ry);
      waitDone(0);
      if ($urandom_range(0, 1) == 1) checkHold();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
